// File: rtl/alu_arbiter_if.sv
// Requester-side bus of alu_arbiter: per-requester request slices plus the shared,
// ID-tagged response channel.
interface alu_arbiter_if #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned OP_W   = 4,
    parameter int unsigned RES_W  = 16
);
    localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*DATA_W-1:0] req_a;
    logic [N_REQ*DATA_W-1:0] req_b;
    logic [N_REQ*OP_W-1:0]   req_op;
    logic                    rsp_valid;
    logic [ID_W-1:0]         rsp_id;
    logic [RES_W-1:0]        rsp_data;

    modport master (
        output req_valid, req_a, req_b, req_op,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin scheduler sharing one fixed-latency ALU among N_REQ requesters,
// with one outstanding operation per requester and ID-tagged responses.
module alu_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned OP_W    = 4,
    parameter int unsigned RES_W   = 16,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_arbiter_if.slave      bus,
    input  logic              arb_hold,
    output logic              alu_en,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [RES_W-1:0]  alu_out,
    output logic              busy
);
    localparam int unsigned ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned PIPE_W = ALU_LAT * ID_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t                          state, state_nxt;
    logic [N_REQ-1:0]                pending, pending_nxt;
    logic [N_REQ-1:0]                grant;
    logic [ID_W-1:0]                 rr_ptr;
    logic [ID_W-1:0]                 grant_id;
    logic [ID_W-1:0]                 scan_idx;
    logic [ID_W-1:0]                 issue_id;
    logic                            hs;
    logic [ALU_LAT-1:0]              rsp_vld_pipe;
    logic [ALU_LAT-1:0][ID_W-1:0]    rsp_id_pipe;
    logic                            rsp_valid;
    logic [ID_W-1:0]                 rsp_id;

    assign rsp_valid = rsp_vld_pipe[ALU_LAT-1];
    assign rsp_id    = rsp_id_pipe[ALU_LAT-1];

    // First eligible requester at or after rr_ptr; ready already implies valid,
    // so any grant is a handshake.
    always_comb begin : grant_search
        grant    = '0;
        grant_id = '0;
        scan_idx = '0;
        hs       = 1'b0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            scan_idx = ID_W'((32'(rr_ptr) + off) % N_REQ);
            if (!hs && rst_n && !arb_hold && bus.req_valid[scan_idx] && !pending[scan_idx]) begin
                hs       = 1'b1;
                grant_id = scan_idx;
            end
        end
        if (hs) begin
            grant[grant_id] = 1'b1;
        end
    end

    always_comb begin : pending_update
        pending_nxt = pending;
        if (rsp_valid) begin
            pending_nxt[rsp_id] = 1'b0;
        end
        if (hs) begin
            pending_nxt[grant_id] = 1'b1;
        end
    end

    always_comb begin : fsm_next
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (hs) state_nxt = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (pending_nxt == '0) state_nxt = ST_IDLE;
                else if (arb_hold)     state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (pending_nxt == '0) state_nxt = ST_IDLE;
                else if (!arb_hold)    state_nxt = ST_ACTIVE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // alu_en doubles as the valid of issue_id, the stage ahead of the response pipe.
    always_ff @(posedge clk or negedge rst_n) begin : seq
        if (!rst_n) begin
            state        <= ST_IDLE;
            pending      <= '0;
            rr_ptr       <= '0;
            alu_en       <= 1'b0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_op       <= '0;
            issue_id     <= '0;
            rsp_vld_pipe <= '0;
            rsp_id_pipe  <= '0;
        end else begin
            state        <= state_nxt;
            pending      <= pending_nxt;
            alu_en       <= hs;
            rsp_vld_pipe <= (rsp_vld_pipe << 1) | ALU_LAT'(alu_en);
            rsp_id_pipe  <= (rsp_id_pipe << ID_W) | PIPE_W'(issue_id);
            if (hs) begin
                rr_ptr   <= ID_W'((32'(grant_id) + 1) % N_REQ);
                alu_a    <= bus.req_a[grant_id*DATA_W +: DATA_W];
                alu_b    <= bus.req_b[grant_id*DATA_W +: DATA_W];
                alu_op   <= bus.req_op[grant_id*OP_W +: OP_W];
                issue_id <= grant_id;
            end
        end
    end

    assign busy          = (state != ST_IDLE);
    assign bus.req_ready = grant;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_id    = rsp_id;
    assign bus.rsp_data  = rsp_valid ? alu_out : '0;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios and randomized traffic checked against a
// transaction-level model (pending set, round-robin pointer, queue of in-flight ops).
module tb_alu_arbiter;
    localparam int unsigned N   = 4;
    localparam int unsigned DW  = 8;
    localparam int unsigned OW  = 4;
    localparam int unsigned RW  = 16;
    localparam int unsigned LAT = 1;
    localparam int unsigned IW  = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          arb_hold;
    logic          alu_en;
    logic [DW-1:0] alu_a, alu_b;
    logic [OW-1:0] alu_op;
    logic [RW-1:0] alu_out;
    logic          busy;

    alu_arbiter_if #(.N_REQ(N), .DATA_W(DW), .OP_W(OW), .RES_W(RW)) bus ();

    alu_arbiter #(.N_REQ(N), .DATA_W(DW), .OP_W(OW), .RES_W(RW), .ALU_LAT(LAT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .arb_hold (arb_hold),
        .alu_en   (alu_en),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_op   (alu_op),
        .alu_out  (alu_out),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [RW-1:0] alu_fn(logic [DW-1:0] a, logic [DW-1:0] b, logic [OW-1:0] op);
        case (op[1:0])
            2'd0:    return RW'(a) + RW'(b);
            2'd1:    return RW'(a) - RW'(b);
            2'd2:    return RW'(a) * RW'(b);
            default: return RW'(a ^ b);
        endcase
    endfunction

    // External ALU with LAT cycles from alu_en to result
    logic [RW-1:0] alu_pipe [LAT];
    always @(posedge clk) begin
        alu_pipe[0] <= alu_en ? alu_fn(alu_a, alu_b, alu_op) : '0;
        for (int j = 1; j < LAT; j++) alu_pipe[j] <= alu_pipe[j-1];
    end
    assign alu_out = alu_pipe[LAT-1];

    typedef struct { int id; logic [RW-1:0] data; int due; } op_t;
    typedef struct {
        logic [N-1:0] rdy; logic en; logic [DW-1:0] a; logic [DW-1:0] b; logic [OW-1:0] op;
        logic rv; logic [IW-1:0] rid; logic [RW-1:0] rd; logic busy;
    } snap_t;

    op_t           inflight[$];
    int            gnt_log[$];
    bit [N-1:0]    m_pend;
    int            m_ptr;
    bit            m_en;
    logic [DW-1:0] m_a, m_b;
    logic [OW-1:0] m_op;
    bit            m_busy;
    int            cyc, cur_g, last_g;
    int            n_cmp, n_bad, n_rsp;
    snap_t         snap;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int model_grant();
        if (rst_n !== 1'b1 || arb_hold) return -1;
        for (int o = 0; o < int'(N); o++) begin
            int i;
            i = (m_ptr + o) % N;
            if (bus.req_valid[i] && !m_pend[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        inflight.delete();
        m_pend = '0; m_ptr = 0; m_en = 0; m_busy = 0;
        m_a = '0; m_b = '0; m_op = '0;
        cur_g = -1; last_g = -1;
    endtask

    task automatic new_fields(int i);
        bus.req_a[i*DW +: DW]  = DW'($urandom);
        bus.req_b[i*DW +: DW]  = DW'($urandom);
        bus.req_op[i*OW +: OW] = OW'($urandom);
    endtask

    task automatic sample_and_check();
        int k;
        k = -1;
        snap = '{bus.req_ready, alu_en, alu_a, alu_b, alu_op, bus.rsp_valid, bus.rsp_id, bus.rsp_data, busy};
        cur_g = model_grant();
        chk("req_ready", 32'(snap.rdy), (cur_g >= 0) ? (32'd1 << cur_g) : 32'd0);
        chk("alu_en", 32'(snap.en), 32'(m_en));
        chk("alu_a", 32'(snap.a), 32'(m_a));
        chk("alu_b", 32'(snap.b), 32'(m_b));
        chk("alu_op", 32'(snap.op), 32'(m_op));
        foreach (inflight[i]) if (inflight[i].due == cyc) k = i;
        chk("rsp_valid", 32'(snap.rv), 32'(k >= 0));
        if (k >= 0) begin
            chk("rsp_id", 32'(snap.rid), inflight[k].id);
            chk("rsp_data", 32'(snap.rd), 32'(inflight[k].data));
        end
        chk("busy", 32'(snap.busy), 32'(m_busy));
    endtask

    task automatic model_edge();
        int k;
        k = -1;
        last_g = -1;
        if (rst_n === 1'b1) begin
            foreach (inflight[i]) if (inflight[i].due == cyc) k = i;
            if (k >= 0) begin
                m_pend[inflight[k].id] = 1'b0;
                inflight.delete(k);
            end
            if (cur_g >= 0) begin
                m_pend[cur_g] = 1'b1;
                m_ptr = (cur_g + 1) % N;
                m_a   = bus.req_a[cur_g*DW +: DW];
                m_b   = bus.req_b[cur_g*DW +: DW];
                m_op  = bus.req_op[cur_g*OW +: OW];
                inflight.push_back('{cur_g, alu_fn(m_a, m_b, m_op), cyc + 1 + int'(LAT)});
                gnt_log.push_back(cur_g);
                last_g = cur_g;
                m_en = 1'b1;
            end else begin
                m_en = 1'b0;
            end
            m_busy = |m_pend;
        end
        cyc++;
    endtask

    // One cycle: check outputs at negedge, advance model at posedge, then drive new inputs.
    task automatic step(bit rnd);
        @(negedge clk);
        sample_and_check();
        if (snap.rv === 1'b1) n_rsp++;
        @(posedge clk);
        model_edge();
        #1;
        for (int i = 0; i < int'(N); i++) begin
            if (i == last_g || (rnd && !bus.req_valid[i])) new_fields(i);
            if (rnd) begin
                if (i == last_g || !bus.req_valid[i]) bus.req_valid[i] = 1'($urandom_range(0, 1));
                else if ($urandom_range(0, 7) == 0) bus.req_valid[i] = 1'b0;
            end
        end
        if (rnd && $urandom_range(0, 15) == 0) arb_hold = ~arb_hold;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; n_rsp = 0; cyc = 0;
        arb_hold = 1'b0;
        bus.req_valid = '1;
        for (int i = 0; i < int'(N); i++) new_fields(i);
        model_reset();

        // Reset held with all requesters valid
        repeat (3) step(0);
        chk("rst_ready", 32'(snap.rdy), 32'd0);
        chk("rst_busy", 32'(snap.busy), 32'd0);
        rst_n = 1'b1;

        // Fairness with all requesters valid
        gnt_log.delete();
        for (int s = 0; s < 12; s++) begin
            step(0);
            if (s == 0) chk("first_grant", 32'(snap.rdy), 32'b0001);
            else        chk("fair_alu_en", 32'(snap.en), 32'd1);
        end
        chk("fair_count", gnt_log.size(), 12);
        for (int i = 0; i < gnt_log.size(); i++) chk("fair_order", gnt_log[i], i % 4);
        bus.req_valid = '0;
        repeat (4) step(0);

        // Single ADD request from requester 2
        bus.req_valid = 4'b0100;
        bus.req_a[2*DW +: DW] = 8'd3;
        bus.req_b[2*DW +: DW] = 8'd5;
        bus.req_op[2*OW +: OW] = 4'd0;
        step(0);
        chk("single_ready", 32'(snap.rdy), 32'b0100);
        bus.req_valid = '0;
        step(0);
        chk("single_en", 32'(snap.en), 32'd1);
        chk("single_a", 32'(snap.a), 32'd3);
        chk("single_b", 32'(snap.b), 32'd5);
        step(0);
        chk("single_rv", 32'(snap.rv), 32'd1);
        chk("single_id", 32'(snap.rid), 32'd2);
        chk("single_data", 32'(snap.rd), 32'd8);
        step(0);
        chk("single_busy", 32'(snap.busy), 32'd0);

        // Wrap and skip: only 0 and 3 valid, pointer at 3
        gnt_log.delete();
        bus.req_valid = 4'b1001;
        repeat (4) step(0);
        chk("wrap_count", gnt_log.size(), 3);
        if (gnt_log.size() == 3) begin
            chk("wrap_g0", gnt_log[0], 3);
            chk("wrap_g1", gnt_log[1], 0);
            chk("wrap_g2", gnt_log[2], 3);
        end
        bus.req_valid = '0;
        repeat (4) step(0);

        // Hold and drain
        n_rsp = 0;
        bus.req_valid = '1;
        repeat (3) step(0);
        arb_hold = 1'b1;
        for (int s = 0; s < 8; s++) begin
            step(0);
            chk("hold_ready", 32'(snap.rdy), 32'd0);
            if (s > 0) chk("hold_alu_en", 32'(snap.en), 32'd0);
        end
        chk("hold_rsp_count", n_rsp, 3);
        chk("hold_busy", 32'(snap.busy), 32'd0);
        arb_hold = 1'b0;
        step(0);
        chk("hold_release", 32'(snap.rdy), 32'b1000);
        bus.req_valid = '0;
        repeat (4) step(0);

        // Reset one cycle after alu_en discards the in-flight op
        bus.req_valid = 4'b0010;
        step(0);
        bus.req_valid = '0;
        step(0);
        chk("midrst_en", 32'(snap.en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_rv", 32'(bus.rsp_valid), 32'd0);
        chk("midrst_alu_en", 32'(alu_en), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_alu_a", 32'(alu_a), 32'd0);
        chk("midrst_rid", 32'(bus.rsp_id), 32'd0);
        model_reset();
        n_rsp = 0;
        repeat (2) step(0);
        rst_n = 1'b1;
        repeat (4) step(0);
        chk("midrst_no_rsp", n_rsp, 0);

        // Randomized traffic with random hold
        repeat (800) step(1);
        bus.req_valid = '0;
        arb_hold = 1'b0;
        repeat (6) step(0);
        chk("final_busy", 32'(snap.busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Round-robin arbiter and scheduler that shares one ALU datapath instance between N_REQ requesters.
- Accepts operand/opcode requests over valid/ready handshakes and issues at most one operation per cycle to the ALU.
- Tracks each in-flight operation through the fixed ALU latency and returns the result tagged with the requester ID.
- Sits between the requesting masters and the ALU; the ALU's interface is driven only by this block.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- DATA_W, 8, ALU operand width
- OP_W, 4, ALU opcode width
- RES_W, 16, ALU result width
- ALU_LAT, 1, cycles from alu_en high to valid alu_out (1..4)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester grant; one-hot or zero
- req_a  in  N_REQ*DATA_W  operand A, requester i at slice i
- req_b  in  N_REQ*DATA_W  operand B
- req_op  in  N_REQ*OP_W  opcode
- arb_hold  in  1  blocks new grants; in-flight operations still complete
- alu_en  out  1  operation issue strobe to the ALU
- alu_a  out  DATA_W  operand A to the ALU
- alu_b  out  DATA_W  operand B to the ALU
- alu_op  out  OP_W  opcode to the ALU
- alu_out  in  RES_W  ALU result
- rsp_valid  out  1  response valid; no backpressure
- rsp_id  out  clog2(N_REQ)  ID of the requester owning the response
- rsp_data  out  RES_W  equals alu_out while rsp_valid=1
- busy  out  1  any operation pending

Behaviour:
- Reset values: alu_en, alu_a/b/op, rsp_valid, rsp_id, busy, rr_ptr, pending mask and in-flight pipeline all 0; req_ready=0.
- Reset asserted mid-operation discards all in-flight operations; no response is ever produced for them.
- Eligibility:
  - eligible[i] = req_valid[i] & ~pending[i] & ~arb_hold.
  - Each requester has at most one operation outstanding.
- Grant:
  - Combinational; req_ready[k]=1 for the first eligible index searched from rr_ptr upward, wrapping N_REQ-1 to 0.
  - Handshake = req_valid[k] & req_ready[k] at a clock edge.
- On handshake at edge T:
  - pending[k] set.
  - rr_ptr <= (k+1) mod N_REQ.
  - alu_a/b/op registered from slice k; alu_en=1 during cycle T+1.
  - alu_en=0 in cycles with no handshake; alu_a/b/op hold their last values.
- In-flight tracking: an ID/valid shift pipeline of depth ALU_LAT.
- Response:
  - Issue in cycle E (alu_en=1) gives rsp_valid=1, rsp_id=k, rsp_data=alu_out in cycle E+ALU_LAT.
  - pending[k] clears at the end of that cycle, so requester k is eligible from E+ALU_LAT+1.
- Throughput: one issue per cycle. With N_REQ ≥ ALU_LAT+2 and all requesters valid, alu_en stays continuously high.
- rr_ptr is unchanged in cycles without a handshake.
- Requester protocol:
  - Fields must stay stable while valid is high and ready is low.
  - Dropping valid before the handshake is legal and has no side effect.
- busy = |pending, registered; reflects the pending mask after each edge.
- Controller states (encoded, observable via busy/alu_en):
  - IDLE: pending=0.
  - ACTIVE: pending≠0, hold=0.
  - DRAIN: pending≠0, hold=1.
  - IDLE→ACTIVE on first handshake; ACTIVE→DRAIN on hold; DRAIN→IDLE when the last response returns.
  - Hold deasserted in DRAIN→ACTIVE; hold in IDLE stays IDLE with no grants.
- Simultaneous response and new handshake for different IDs in one cycle: both take effect.
- Same-ID response and new handshake in one cycle cannot occur, because pending blocks it.

Test Plan:
- Reset: hold rst_n=0 with req_valid=4'hF -> req_ready=0, alu_en=0, rsp_valid=0, busy=0; release -> first grant to requester 0.
- Single request (ALU_LAT=1): requester 2, a=3, b=5, ALU ADD opcode -> req_ready[2]=1 at cycle 0; alu_en=1 with a=3, b=5 at cycle 1; rsp_valid=1, rsp_id=2, rsp_data=8 at cycle 2; busy=0 at cycle 3.
- Fairness: req_valid=4'hF held continuously, ALU_LAT=1 -> grant order 0,1,2,3,0,1,…; alu_en high every cycle after the first; each rsp_id matches its issue order.
- Wrap and skip: after a grant to 3, only requesters 0 and 3 valid -> next grant 0, then 3.
- Hold/drain: assert arb_hold with 3 operations in flight -> req_ready=0; all 3 responses return; busy falls; no further alu_en until hold is released.
- Mid-op reset: assert rst_n=0 one cycle after alu_en -> no rsp_valid is ever seen for that operation; all outputs are 0 within the reset cycle.
